fp_addsub_seq: RTL and testbench

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_addsub_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor.
// Operands are sign|exponent|fraction words with no subnormal support.
// Specials (NaN, Inf, zero) are resolved at accept time and go straight to DONE.
// Everything else goes through ALIGN -> ADD -> NORM. Rounding truncates toward zero.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 op_q, op_d;
  logic                 big_sign_q, big_sign_d;
  logic                 eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [MAN_W:0]       big_sig_q, big_sig_d;
  logic [MAN_W:0]       small_sig_q, small_sig_d;
  logic [MAN_W+1:0]     sum_q, sum_d;
  logic [W-1:0]         result_q, result_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  // Field views of the live input operands, used for special-case decode at accept.
  logic                 in_a_sign, in_b_esign;
  logic [EXP_W-1:0]     in_a_exp, in_b_exp;
  logic [MAN_W-1:0]     in_a_frac, in_b_frac;
  logic                 in_a_nan, in_b_nan, in_a_inf, in_b_inf, in_a_zero, in_b_zero;
  logic                 in_special;
  logic [W-1:0]         spec_result;
  logic                 spec_invalid;

  // Field views of the registered operands, used by ALIGN.
  logic                 q_a_sign, q_b_esign;
  logic [EXP_W-1:0]     q_a_exp, q_b_exp, exp_diff;
  logic [MAN_W-1:0]     q_a_frac, q_b_frac;
  logic                 a_is_big;
  logic [MAN_W:0]       small_raw;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

  // Decode NaN/Inf/zero on the incoming operands and pick the bypass result.
  always_comb begin
    in_a_sign  = a[W-1];
    in_b_esign = b[W-1] ^ op;
    in_a_exp   = a[W-2:MAN_W];
    in_b_exp   = b[W-2:MAN_W];
    in_a_frac  = a[MAN_W-1:0];
    in_b_frac  = b[MAN_W-1:0];
    in_a_nan   = (in_a_exp == EXP_ONES) && (in_a_frac != '0);
    in_b_nan   = (in_b_exp == EXP_ONES) && (in_b_frac != '0);
    in_a_inf   = (in_a_exp == EXP_ONES) && (in_a_frac == '0);
    in_b_inf   = (in_b_exp == EXP_ONES) && (in_b_frac == '0);
    in_a_zero  = (in_a_exp == EXP_ZERO);
    in_b_zero  = (in_b_exp == EXP_ZERO);
    in_special = in_a_nan | in_b_nan | in_a_inf | in_b_inf | in_a_zero | in_b_zero;
    spec_invalid = 1'b0;
    spec_result  = '0;
    if (in_a_nan || in_b_nan || (in_a_inf && in_b_inf && (in_a_sign != in_b_esign))) begin
      spec_result  = QNAN;
      spec_invalid = 1'b1;
    end else if (in_a_inf) begin
      spec_result = a;
    end else if (in_b_inf) begin
      spec_result = {in_b_esign, b[W-2:0]};
    end else if (in_a_zero && in_b_zero) begin
      // Zero exponent means zero regardless of fraction, so the fraction is cleared.
      spec_result = {in_a_sign & in_b_esign, {(W-1){1'b0}}};
    end else if (in_a_zero) begin
      spec_result = {in_b_esign, b[W-2:0]};
    end else begin
      spec_result = a;
    end
  end

  // Pick the larger-magnitude operand and pre-shift the smaller significand.
  always_comb begin
    q_a_sign  = a_q[W-1];
    q_b_esign = b_q[W-1] ^ op_q;
    q_a_exp   = a_q[W-2:MAN_W];
    q_b_exp   = b_q[W-2:MAN_W];
    q_a_frac  = a_q[MAN_W-1:0];
    q_b_frac  = b_q[MAN_W-1:0];
    // Exponent and fraction sit side by side, so one unsigned compare orders magnitudes.
    a_is_big  = (a_q[W-2:0] >= b_q[W-2:0]);
    exp_diff  = a_is_big ? (q_a_exp - q_b_exp) : (q_b_exp - q_a_exp);
    small_raw = a_is_big ? {1'b1, q_b_frac} : {1'b1, q_a_frac};
  end

  // Next-state and datapath computation for the whole operation sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    big_sign_d  = big_sign_q;
    eff_sub_d   = eff_sub_q;
    exp_d       = exp_q;
    big_sig_d   = big_sig_q;
    small_sig_d = small_sig_q;
    sum_d       = sum_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inv_d       = inv_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d   = a;
          b_d   = b;
          op_d  = op;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inv_d = 1'b0;
          if (in_special) begin
            result_d = spec_result;
            inv_d    = spec_invalid;
            state_d  = S_DONE;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        big_sign_d = a_is_big ? q_a_sign : q_b_esign;
        eff_sub_d  = q_a_sign ^ q_b_esign;
        exp_d      = a_is_big ? q_a_exp : q_b_exp;
        big_sig_d  = a_is_big ? {1'b1, q_a_frac} : {1'b1, q_b_frac};
        // Shifting by the full significand width or more leaves nothing behind.
        if (int'(exp_diff) >= MAN_W + 1)
          small_sig_d = '0;
        else
          small_sig_d = small_raw >> exp_diff;
        state_d = S_ADD;
      end
      S_ADD: begin
        // The larger operand is always the minuend, so the difference is never negative.
        if (eff_sub_q)
          sum_d = {1'b0, big_sig_q} - {1'b0, small_sig_q};
        else
          sum_d = {1'b0, big_sig_q} + {1'b0, small_sig_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q[MAN_W+1]) begin
          // Carry out: one right shift, dropped LSB is the truncation.
          if (exp_q == EXP_ONES - EXP_W'(1)) begin
            result_d = {big_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {big_sign_q, exp_q + EXP_W'(1), sum_q[MAN_W:1]};
          end
          state_d = S_DONE;
        end else if (sum_q == '0) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (sum_q[MAN_W]) begin
          result_d = {big_sign_q, exp_q, sum_q[MAN_W-1:0]};
          state_d  = S_DONE;
        end else if (exp_q <= EXP_W'(1)) begin
          // Another left shift would drop the exponent to zero, which encodes zero.
          result_d = {big_sign_q, {(W-1){1'b0}}};
          unf_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          sum_d = {sum_q[MAN_W:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      big_sign_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      big_sig_q   <= '0;
      small_sig_q <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      big_sign_q  <= big_sign_d;
      eff_sub_q   <= eff_sub_d;
      exp_q       <= exp_d;
      big_sig_q   <= big_sig_d;
      small_sig_q <= small_sig_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq (single precision defaults).
module tb_fp_addsub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one operation; lat counts rising edges from the accept edge to out_valid.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                        output logic [31:0] res, output logic [2:0] flg, output int lat);
    @(negedge clk);
    a = ta; b = tbv; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    flg = {overflow, underflow, invalid};
  endtask

  // Complete the output handshake so the block returns to IDLE.
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_vec(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic top, input logic [31:0] exp_res, input logic [2:0] exp_flg,
                        input int exp_lat);
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    run_op(ta, tbv, top, res, flg, lat);
    $display("vec %s: a=%h b=%h op=%0d -> result=%h ovf/unf/inv=%b latency=%0d",
             tag, ta, tbv, top, res, flg, lat);
    check({tag, ".result"}, res, exp_res);
    check({tag, ".flags"}, {29'd0, flg}, {29'd0, exp_flg});
    check({tag, ".latency"}, lat, exp_lat);
    handshake();
  endtask

  initial begin
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.flags", {29'd0, overflow, underflow, invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //      tag        a             b             op    result        flags  lat
    do_vec("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
    do_vec("1p5_minus_1",  32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000, 5);
    do_vec("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 4);
    do_vec("underflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 4);
    do_vec("inf_m_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 1);
    do_vec("inf_p_inf",    32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000, 1);
    do_vec("nan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 1);
    do_vec("negz_p_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1);
    do_vec("negz_m_negz",  32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000, 1);
    do_vec("zero_m_one",   32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 1);
    do_vec("cancel",       32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b000, 4);
    do_vec("two_p_one",    32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 4);
    do_vec("shift_out",    32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000, 4);
    do_vec("lsb_keep",     32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, 4);
    do_vec("neg_result",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 5);
    do_vec("deep_norm",    32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 27);

    // Back-pressure: result and flags must hold while out_ready stays low.
    out_ready = 1'b0;
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, flg, lat);
    $display("vec stall: result=%h ovf/unf/inv=%b latency=%0d", res, flg, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall.result", result, 32'h7F800000);
      check("stall.flags", {29'd0, overflow, underflow, invalid}, 32'd4);
      check("stall.out_valid", {31'd0, out_valid}, 32'd1);
      check("stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    handshake();
    check("stall.released", {31'd0, in_ready}, 32'd1);

    // Reset pulse while the long normalisation is in progress.
    @(negedge clk);
    a = 32'h3F800001; b = 32'h3F800000; op = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst.result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      check("midrst.no_output", {31'd0, out_valid}, 32'd0);
    end
    $display("vec midrst: reset applied during NORM");
    do_vec("after_rst", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
